id_rndn_axil_slave: RTL and testbench
=====================================

Name: id_rndn_axil_slave

Overview:
AXI4-Lite slave (responder) end of the ID_RndN register interface that the bench's master VIP drives. It holds four 32-bit registers: control, seed, random output and step count. It also contains a 32-bit Galois LFSR random generator. It sits in the ID_RndN IP behind the interconnect and serves single-beat AXI4-Lite reads and writes with one outstanding transaction per direction.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.
LFSR_POLY, 32'h80200003, Galois feedback mask.
RESET_SEED, 32'h00000001, LFSR value after reset and substitute for a zero seed.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready

Behaviour:
- Reset, asynchronous: all READY/VALID outputs 0, BRESP/RRESP 2'b00, RDATA 0. CTRL 0, SEED 0, LFSR RESET_SEED, COUNT 0.
- Register map:
  - 0x0 CTRL, R/W. [0] run. [1] seed_load, self-clearing. [2] step, self-clearing. Reads return [0] only; other bits read 0.
  - 0x4 SEED, R/W.
  - 0x8 RND, RO, current LFSR value.
  - 0xC COUNT, RO, LFSR advances since the last seed load; wraps 0xFFFFFFFF->0.
- Write path:
  - AWREADY=1 while no address is latched and BVALID=0. WREADY=1 while no data is latched and BVALID=0.
  - AW and W are accepted independently, in either order or the same cycle.
  - The cycle after both are latched: apply the write under WSTRB byte masking, set BVALID=1 and clear both latches.
  - BVALID holds with BRESP stable until BREADY.
  - Write to RND or COUNT: no state change, BRESP=SLVERR (2'b10). Otherwise OKAY.
  - Write states: IDLE, HAVE_AW, HAVE_W, RESP.
- Read path:
  - ARREADY=1 while RVALID=0.
  - On AR handshake, the next cycle sets RVALID=1 with RDATA sampled from the register, RRESP=OKAY.
  - RDATA/RRESP hold until RREADY. Minimum 2-cycle read latency.
- LFSR update, one source per cycle, priority order:
  1. seed_load: LFSR<=SEED, or RESET_SEED if SEED==0. COUNT<=0.
  2. run or step: LFSR<=(LFSR>>1) ^ (LFSR[0] ? LFSR_POLY : 0). COUNT<=COUNT+1.
  3. Otherwise hold.
- The seed_load and step bits act in the cycle after the CTRL write, then clear. seed_load and step written together: seed_load wins and step is dropped.
- Read of RND in the same cycle as an advance returns the pre-advance value.
- Simultaneous read and write are independent; a read sees the register value from the cycle of the AR handshake.
- Reset mid-transaction drops any latched AW/W and any pending response without emitting it.

Decomposition:
- Package id_rndn_pkg holds:
  - register offsets: REG_CTRL, REG_SEED, REG_RND, REG_COUNT
  - CTRL bit indices
  - RESP_OKAY / RESP_SLVERR constants
  - the write-FSM state enum
- One sub-module, id_rndn_lfsr: seed/load/step/run inputs, 32-bit value and count outputs.

Test Plan:
- Reset, then write SEED=0x00000001 and CTRL=0x2 -> reads give RND=0x00000001, COUNT=0, BRESP=OKAY on both writes.
- CTRL=0x4 twice, with reads after each -> RND=0x80200003 then 0xC0300002; COUNT=1 then 2; CTRL reads 0x0.
- SEED=0x00000000, then CTRL=0x2 -> RND=0x00000001; writing CTRL=0x6 -> RND=0x00000001, COUNT=0 (step dropped).
- W presented 3 cycles before AW, SEED=0xA5A5A5A5 with WSTRB=4'b0011 over an old 0x00000000 -> read SEED=0x0000A5A5; exactly one BVALID pulse.
- Write 0x12345678 to 0x8 -> BRESP=SLVERR, RND unchanged. Read 0x8 holding RREADY=0 for 5 cycles -> RVALID and RDATA stable until RREADY.
- Assert ARESET while BVALID=1 and BREADY=0 -> BVALID=0 immediately; CTRL, SEED, COUNT=0 and RND=0x00000001 on the next read.

Source files
------------

// File: rtl/id_rndn_pkg.sv
// Shared definitions for the ID_RndN AXI4-Lite register block:
// register map, CTRL bit positions, response codes and write-FSM states.
package id_rndn_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_SEED  = 2'd1;
    localparam logic [1:0] REG_RND   = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    localparam int CTRL_RUN       = 0;
    localparam int CTRL_SEED_LOAD = 1;
    localparam int CTRL_STEP      = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/id_rndn_lfsr.sv
// 32-bit Galois LFSR with a seed-load port and an advance counter.
// Load has priority over run/step; a zero seed falls back to RESET_SEED.
module id_rndn_lfsr #(
    parameter logic [31:0] LFSR_POLY  = 32'h80200003,
    parameter logic [31:0] RESET_SEED = 32'h00000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        load,
    input  logic        step,
    input  logic        run,
    output logic [31:0] value,
    output logic [31:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= RESET_SEED;
            count <= 32'd0;
        end else if (load) begin
            value <= (seed == 32'd0) ? RESET_SEED : seed;
            count <= 32'd0;
        end else if (run || step) begin
            value <= (value >> 1) ^ (value[0] ? LFSR_POLY : 32'd0);
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/id_rndn_axil_slave.sv
// AXI4-Lite responder for the ID_RndN registers (CTRL, SEED, RND, COUNT).
// One outstanding transaction per direction; AW and W may arrive in any order.
module id_rndn_axil_slave
    import id_rndn_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] LFSR_POLY          = 32'h80200003,
    parameter logic [31:0] RESET_SEED         = 32'h00000001
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    wr_state_t   state, state_nx;
    logic        ready_en;
    logic [1:0]  aw_idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_hs, w_hs, ar_hs, wr_fire;
    logic [1:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] ctrl_wr, seed_wr, rd_mux;
    logic        ctrl_run, ctrl_load, ctrl_step;
    logic [31:0] seed;
    logic [31:0] lfsr_value, lfsr_count;
    logic        unused_inputs;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    // Keeps every READY low while reset is asserted and for the first edge after.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= WR_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            WR_IDLE: begin
                if (aw_hs && w_hs) state_nx = WR_RESP;
                else if (aw_hs)    state_nx = WR_HAVE_AW;
                else if (w_hs)     state_nx = WR_HAVE_W;
            end
            WR_HAVE_AW: if (w_hs)         state_nx = WR_RESP;
            WR_HAVE_W:  if (aw_hs)        state_nx = WR_RESP;
            WR_RESP:    if (S_AXI_BREADY) state_nx = WR_IDLE;
            default:                      state_nx = WR_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = ready_en && ((state == WR_IDLE) || (state == WR_HAVE_W));
        S_AXI_WREADY  = ready_en && ((state == WR_IDLE) || (state == WR_HAVE_AW));
        S_AXI_BVALID  = (state == WR_RESP);
    end

    always_ff @(posedge ACLK) begin
        if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
        if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
        end
    end

    // The half that completes last comes straight from the bus, the other from its latch.
    assign wr_fire = (state != WR_RESP) && (state_nx == WR_RESP);
    assign wr_idx  = (state == WR_HAVE_AW) ? aw_idx_q : S_AXI_AWADDR[3:2];
    assign wr_data = (state == WR_HAVE_W)  ? wdata_q  : S_AXI_WDATA;
    assign wr_strb = (state == WR_HAVE_W)  ? wstrb_q  : S_AXI_WSTRB;

    assign ctrl_wr = apply_wstrb({29'd0, ctrl_step, ctrl_load, ctrl_run}, wr_data, wr_strb);
    assign seed_wr = apply_wstrb(seed, wr_data, wr_strb);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_run    <= 1'b0;
            ctrl_load   <= 1'b0;
            ctrl_step   <= 1'b0;
            seed        <= 32'd0;
            S_AXI_BRESP <= RESP_OKAY;
        end else begin
            ctrl_load <= 1'b0;
            ctrl_step <= 1'b0;
            if (wr_fire) begin
                S_AXI_BRESP <= RESP_OKAY;
                case (wr_idx)
                    REG_CTRL: begin
                        ctrl_run  <= ctrl_wr[CTRL_RUN];
                        ctrl_load <= ctrl_wr[CTRL_SEED_LOAD];
                        ctrl_step <= ctrl_wr[CTRL_STEP];
                    end
                    REG_SEED: seed <= seed_wr;
                    default:  S_AXI_BRESP <= RESP_SLVERR;
                endcase
            end
        end
    end

    id_rndn_lfsr #(
        .LFSR_POLY  (LFSR_POLY),
        .RESET_SEED (RESET_SEED)
    ) u_lfsr (
        .clk   (ACLK),
        .rst   (ARESET),
        .seed  (seed),
        .load  (ctrl_load),
        .step  (ctrl_step),
        .run   (ctrl_run),
        .value (lfsr_value),
        .count (lfsr_count)
    );

    always_comb begin
        rd_mux = 32'd0;
        case (S_AXI_ARADDR[3:2])
            REG_CTRL:  rd_mux = {31'd0, ctrl_run};
            REG_SEED:  rd_mux = seed;
            REG_RND:   rd_mux = lfsr_value;
            REG_COUNT: rd_mux = lfsr_count;
            default:   rd_mux = 32'd0;
        endcase
    end

    assign S_AXI_ARREADY = ready_en && !S_AXI_RVALID;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_mux;
            S_AXI_RRESP  <= RESP_OKAY;
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_rndn_axil_slave.sv
// Directed bench for id_rndn_axil_slave: a register-level model predicts every
// read and write response; literal values from the register map pin the model.
module tb_id_rndn_axil_slave;

    localparam logic [31:0] POLY = 32'h80200003;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;

    always #5 clk = ~clk;

    id_rndn_axil_slave dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register-level model of the block
    logic        m_run;
    logic [31:0] m_seed, m_lfsr, m_count;

    task automatic model_reset();
        m_run = 1'b0; m_seed = 32'd0; m_lfsr = 32'd1; m_count = 32'd0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? POLY : 32'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] idx);
        case (idx)
            2'd0:    return {31'd0, m_run};
            2'd1:    return m_seed;
            2'd2:    return m_lfsr;
            default: return m_count;
        endcase
    endfunction

    task automatic model_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (idx == 2'd0) begin
            w = merge({31'd0, m_run}, d, s);
            m_run = w[0];
            if (w[1]) begin
                m_lfsr  = (m_seed == 32'd0) ? 32'd1 : m_seed;
                m_count = 32'd0;
            end else if (w[2]) begin
                m_lfsr  = lfsr_next(m_lfsr);
                m_count = m_count + 32'd1;
            end
        end else if (idx == 2'd1) begin
            m_seed = merge(m_seed, d, s);
        end
    endtask

    // Compare process: every cycle a response is on the bus, check it against the model.
    logic        rd_armed = 1'b0, b_armed = 1'b0, b_prev = 1'b0;
    logic [31:0] rd_exp = 32'd0;
    logic [1:0]  b_exp = 2'b00;
    int          b_pulses = 0;

    always @(negedge clk) begin
        if (!rst && rd_armed && rvalid) begin
            check("rdata_vs_model", {32'd0, rdata}, {32'd0, rd_exp});
            check("rresp_okay", {62'd0, rresp}, 64'd0);
        end
        if (!rst && b_armed && bvalid)
            check("bresp_vs_model", {62'd0, bresp}, {62'd0, b_exp});
        if (bvalid && !b_prev) b_pulses++;
        b_prev = bvalid;
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, input bit hold_b, input string name);
        bit aw_p, w_p, aw_h, w_h, got;
        int cyc;
        aw_p = 1'b1; w_p = 1'b1; got = 1'b0; cyc = 0;
        b_exp   = (addr[3:2] >= 2'd2) ? 2'b10 : 2'b00;
        b_armed = 1'b1;
        awaddr = addr; wdata = d; wstrb = s;
        while ((aw_p || w_p) && cyc < 40) begin
            awvalid = aw_p && (cyc >= w_lead);
            wvalid  = w_p;
            @(negedge clk);
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_h) aw_p = 1'b0;
            if (w_h)  w_p  = 1'b0;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check({name, "_addr_data_accepted"}, {63'd0, aw_p | w_p}, 64'd0);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bvalid;
        end
        check({name, "_bvalid_seen"}, {63'd0, got}, 64'd1);
        if (got && !hold_b) begin
            bready = 1'b1;
            @(posedge clk); #1;
            bready  = 1'b0;
            b_armed = 1'b0;
            model_write(addr[3:2], d, s);
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, input int hold, input string name,
                            output logic [31:0] d);
        bit pend, hs, got;
        int cyc;
        pend = 1'b1; got = 1'b0; cyc = 0; d = 32'hx;
        rd_exp = model_read(addr[3:2]);
        rd_armed = 1'b1;
        araddr = addr;
        while (pend && cyc < 40) begin
            arvalid = 1'b1;
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk); #1;
            if (hs) pend = 1'b0;
            cyc++;
        end
        arvalid = 1'b0;
        check({name, "_ar_accepted"}, {63'd0, pend}, 64'd0);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rvalid;
        end
        check({name, "_rvalid_seen"}, {63'd0, got}, 64'd1);
        d = rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_held_stable"}, {31'd0, rvalid, rdata}, {31'd0, 1'b1, d});
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready   = 1'b0;
        rd_armed = 1'b0;
    endtask

    logic [31:0] rv;
    int          p0;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        awaddr = 4'd0; awprot = 3'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0;
        bready = 1'b0; araddr = 4'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", {63'd0, awready}, 64'd0);
        check("rst_wready",  {63'd0, wready},  64'd0);
        check("rst_arready", {63'd0, arready}, 64'd0);
        check("rst_bvalid",  {63'd0, bvalid},  64'd0);
        check("rst_rvalid",  {63'd0, rvalid},  64'd0);
        check("rst_rdata",   {32'd0, rdata},   64'd0);
        check("rst_bresp",   {62'd0, bresp},   64'd0);
        check("rst_rresp",   {62'd0, rresp},   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        axi_read(4'h0, 0, "rst_ctrl", rv);  check("rst_ctrl_lit",  {32'd0, rv}, 64'd0);
        axi_read(4'h4, 0, "rst_seed", rv);  check("rst_seed_lit",  {32'd0, rv}, 64'd0);
        axi_read(4'h8, 0, "rst_rnd", rv);   check("rst_rnd_lit",   {32'd0, rv}, 64'h1);
        axi_read(4'hC, 0, "rst_count", rv); check("rst_count_lit", {32'd0, rv}, 64'd0);

        // Seed load with a seed of one
        axi_write(4'h4, 32'h00000001, 4'hF, 0, 1'b0, "wr_seed1");
        axi_write(4'h0, 32'h00000002, 4'hF, 0, 1'b0, "wr_load");
        axi_read(4'h8, 0, "load_rnd", rv);   check("load_rnd_lit",   {32'd0, rv}, 64'h1);
        axi_read(4'hC, 0, "load_count", rv); check("load_count_lit", {32'd0, rv}, 64'd0);

        // Two single steps
        axi_write(4'h0, 32'h00000004, 4'hF, 0, 1'b0, "wr_step1");
        axi_read(4'h8, 0, "step1_rnd", rv);   check("step1_rnd_lit",   {32'd0, rv}, 64'h80200003);
        axi_read(4'hC, 0, "step1_count", rv); check("step1_count_lit", {32'd0, rv}, 64'd1);
        axi_read(4'h0, 0, "step1_ctrl", rv);  check("step1_ctrl_lit",  {32'd0, rv}, 64'd0);
        axi_write(4'h0, 32'h00000004, 4'hF, 0, 1'b0, "wr_step2");
        axi_read(4'h8, 0, "step2_rnd", rv);   check("step2_rnd_lit",   {32'd0, rv}, 64'hC0300002);
        axi_read(4'hC, 0, "step2_count", rv); check("step2_count_lit", {32'd0, rv}, 64'd2);

        // Zero seed substitutes the reset seed; load beats a simultaneous step
        axi_write(4'h4, 32'h00000000, 4'hF, 0, 1'b0, "wr_seed0");
        axi_write(4'h0, 32'h00000002, 4'hF, 0, 1'b0, "wr_load0");
        axi_read(4'h8, 0, "zseed_rnd", rv); check("zseed_rnd_lit", {32'd0, rv}, 64'h1);
        axi_write(4'h0, 32'h00000004, 4'hF, 0, 1'b0, "wr_step3");
        axi_write(4'h0, 32'h00000006, 4'hF, 0, 1'b0, "wr_load_step");
        axi_read(4'h8, 0, "ls_rnd", rv);   check("ls_rnd_lit",   {32'd0, rv}, 64'h1);
        axi_read(4'hC, 0, "ls_count", rv); check("ls_count_lit", {32'd0, rv}, 64'd0);

        // W three cycles ahead of AW, partial strobes
        p0 = b_pulses;
        axi_write(4'h4, 32'hA5A5A5A5, 4'b0011, 3, 1'b0, "wr_w_first");
        check("w_first_one_bvalid_pulse", 64'(b_pulses - p0), 64'd1);
        axi_read(4'h4, 0, "strb_seed", rv); check("strb_seed_lit", {32'd0, rv}, 64'h0000A5A5);
        axi_write(4'h0, 32'h00000002, 4'hF, 0, 1'b0, "wr_load_a5");
        axi_write(4'h0, 32'h00000004, 4'hF, 0, 1'b0, "wr_step_a5");
        axi_read(4'h8, 0, "a5_rnd", rv);
        axi_read(4'hC, 0, "a5_count", rv); check("a5_count_lit", {32'd0, rv}, 64'd1);

        // CTRL write with byte 0 masked leaves CTRL alone
        axi_write(4'h0, 32'hFFFFFFFF, 4'b1110, 0, 1'b0, "wr_ctrl_masked");
        axi_read(4'h0, 0, "masked_ctrl", rv); check("masked_ctrl_lit", {32'd0, rv}, 64'd0);

        // Writes to read-only registers, and a stalled read
        axi_write(4'h8, 32'h12345678, 4'hF, 0, 1'b0, "wr_rnd_ro");
        axi_write(4'hC, 32'h12345678, 4'hF, 0, 1'b0, "wr_count_ro");
        axi_read(4'h8, 5, "ro_rnd_hold", rv); check("ro_rnd_unchanged", {32'd0, rv}, {32'd0, m_lfsr});
        axi_read(4'hC, 0, "ro_count", rv);    check("ro_count_lit", {32'd0, rv}, 64'd1);

        // Reset while a write response is pending
        axi_write(4'h4, 32'h00000011, 4'hF, 0, 1'b1, "wr_pending");
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_bvalid_drop", {63'd0, bvalid}, 64'd0);
        b_armed = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_no_bvalid", {63'd0, bvalid}, 64'd0);
        axi_read(4'h0, 0, "prst_ctrl", rv);  check("prst_ctrl_lit",  {32'd0, rv}, 64'd0);
        axi_read(4'h4, 0, "prst_seed", rv);  check("prst_seed_lit",  {32'd0, rv}, 64'd0);
        axi_read(4'h8, 0, "prst_rnd", rv);   check("prst_rnd_lit",   {32'd0, rv}, 64'h1);
        axi_read(4'hC, 0, "prst_count", rv); check("prst_count_lit", {32'd0, rv}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
